// File: rtl/sample_sequencer.sv
// -----------------------------------------------------------------------------
// sample_sequencer
//
// Plays a stored signal out of a BRAM towards a FIR filter. Each pass reads
// one sample every CLK_DIV clocks, starting at address 0. Each sample is
// registered and presented with a valid/ready handshake.
//
// The FSM runs IDLE -> WAIT_TICK -> READ -> CAPTURE -> PRESENT -> WAIT_TICK ...
// A pass ends in DONE, or wraps to address 0 when i_loop is set.
// The sample-period tick counter free-runs while busy. A tick that arrives
// while a sample is still in flight is dropped and never queued.
//
// Optional feature macro: SAMPLE_SEQ_OVERRUN_EN
//   When defined, a dropped tick sets the sticky o_overrun flag.
//   When undefined, o_overrun is tied to 0 and has no detection logic.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      begin a pass from address 0 (honoured in IDLE/DONE only)
//   i_stop       abort to IDLE; has priority over i_start and transfers
//   i_loop       wrap to address 0 after the last sample instead of finishing
//   o_bram_rden  BRAM read enable (asserted only in READ)
//   o_bram_addr  BRAM read address (holds its last value outside READ)
//   i_bram_data  BRAM read data, valid one cycle after o_bram_rden
//   o_sig_data   sample to FIR, stable while o_sig_valid is high
//   o_sig_valid  sample valid to FIR
//   i_fir_ready  FIR accepts the sample
//   o_busy       pass in progress
//   o_done       pass completed; held until i_start, i_stop or reset
//   o_overrun    sticky flag for a missed sample tick
// -----------------------------------------------------------------------------
module sample_sequencer #(
    parameter int SIG_WIDTH = 16,
    parameter int ADDR_W    = 7,
    parameter int SIG_LEN   = 100,
    parameter int CLK_DIV   = 12000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_loop,
    output logic                 o_bram_rden,
    output logic [ADDR_W-1:0]    o_bram_addr,
    input  logic [SIG_WIDTH-1:0] i_bram_data,
    output logic [SIG_WIDTH-1:0] o_sig_data,
    output logic                 o_sig_valid,
    input  logic                 i_fir_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun
);

    localparam int                 CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0]  IDX_LAST = ADDR_W'(SIG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_READ,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [ADDR_W-1:0]      idx_q,   idx_d;
    logic [ADDR_W-1:0]      addr_q,  addr_d;
    logic [SIG_WIDTH-1:0]   data_q,  data_d;

    logic running;
    logic tick;
    logic restart;

    assign running = (state_q == S_WAIT_TICK) || (state_q == S_READ) ||
                     (state_q == S_CAPTURE)   || (state_q == S_PRESENT);
    assign tick    = running && (cnt_q == CNT_LAST);
    // i_stop outranks i_start, so a simultaneous pair leaves the FSM idle.
    assign restart = i_start && !i_stop &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (running) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (restart) begin
                    state_d = S_WAIT_TICK;
                    idx_d   = '0;
                    // Cleared here so the first tick lands CLK_DIV cycles after i_start.
                    cnt_d   = '0;
                end
            end
            S_WAIT_TICK: begin
                if (tick) begin
                    state_d = S_READ;
                    addr_d  = idx_q;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d  = i_bram_data;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (i_fir_ready) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_WAIT_TICK;
                    end else if (i_loop) begin
                        idx_d   = '0;
                        state_d = S_WAIT_TICK;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_stop) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_bram_rden = (state_q == S_READ);
    assign o_bram_addr = addr_q;
    assign o_sig_data  = data_q;
    assign o_sig_valid = (state_q == S_PRESENT);
    assign o_busy      = running;
    assign o_done      = (state_q == S_DONE);

`ifdef SAMPLE_SEQ_OVERRUN_EN
    logic overrun_q, overrun_d;
    logic drop;

    // A tick that lands while a sample is still in flight is lost.
    assign drop = tick && ((state_q == S_READ) || (state_q == S_CAPTURE) ||
                           (state_q == S_PRESENT));

    always_comb begin
        overrun_d = overrun_q;
        if (restart) begin
            overrun_d = 1'b0;
        end else if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
module tb_sample_sequencer;

    localparam int SW = 16;
    localparam int AW = 3;
    localparam int SL = 4;
    localparam int CD = 4;

`ifdef SAMPLE_SEQ_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          bram_rden;
    logic [AW-1:0] bram_addr;
    logic [SW-1:0] bram_data;
    logic [SW-1:0] sig_data;
    logic          sig_valid;
    logic          fir_ready;
    logic          busy;
    logic          done;
    logic          overrun;

    always #5 clk = ~clk;

    sample_sequencer #(
        .SIG_WIDTH (SW),
        .ADDR_W    (AW),
        .SIG_LEN   (SL),
        .CLK_DIV   (CD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_loop      (loop_en),
        .o_bram_rden (bram_rden),
        .o_bram_addr (bram_addr),
        .i_bram_data (bram_data),
        .o_sig_data  (sig_data),
        .o_sig_valid (sig_valid),
        .i_fir_ready (fir_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_overrun   (overrun)
    );

    // BRAM model: one-cycle read latency; contents 0x0010, 0x0020, ...
    logic [SW-1:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = SW'((i + 1) * 16);
        bram_data = '0;
    end
    always @(posedge clk) begin
        if (bram_rden) bram_data <= mem[bram_addr];
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            xfers  = 0;
    logic [SW-1:0] sb_q [$];
    logic          prev_stall = 1'b0;
    logic [SW-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Scoreboard consumer: every accepted sample must match the next expected value,
    // and a stalled sample must not change.
    always @(negedge clk) begin
        logic [SW-1:0] exp_v;
        if (rst === 1'b0 && sig_valid === 1'b1) begin
            if (prev_stall) chk("hold_data", 32'(sig_data), 32'(prev_data));
            if (fir_ready === 1'b1) begin
                xfers++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=%0h required=none", sig_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("sb_data", 32'(sig_data), 32'(exp_v));
                end
            end
        end
        prev_stall = (rst === 1'b0) && (sig_valid === 1'b1) && (fir_ready !== 1'b1);
        prev_data  = sig_data;
    end

    typedef struct {
        int            c;
        logic          start;
        logic          rden;
        logic [AW-1:0] addr;
        logic          valid;
        logic [SW-1:0] data;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tv [14];

    initial begin
        int k;
        int bad;
        int x0;

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; fir_ready = 1'b1;

        tv[0]  = '{1,  1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[1]  = '{4,  1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2]  = '{5,  1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[3]  = '{6,  1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[4]  = '{7,  1'b0, 1'b0, 3'd0, 1'b1, 16'h0010, 1'b1, 1'b0};
        tv[5]  = '{9,  1'b0, 1'b1, 3'd1, 1'b0, 16'h0010, 1'b1, 1'b0};
        tv[6]  = '{10, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0010, 1'b1, 1'b0};
        tv[7]  = '{11, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0020, 1'b1, 1'b0};
        tv[8]  = '{13, 1'b0, 1'b1, 3'd2, 1'b0, 16'h0020, 1'b1, 1'b0};
        tv[9]  = '{15, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0030, 1'b1, 1'b0};
        tv[10] = '{17, 1'b0, 1'b1, 3'd3, 1'b0, 16'h0030, 1'b1, 1'b0};
        tv[11] = '{19, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0040, 1'b1, 1'b0};
        tv[12] = '{20, 1'b0, 1'b0, 3'd3, 1'b0, 16'h0040, 1'b0, 1'b1};
        tv[13] = '{23, 1'b0, 1'b0, 3'd3, 1'b0, 16'h0040, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rden",    32'(bram_rden), 0);
        chk("rst_addr",    32'(bram_addr), 0);
        chk("rst_data",    32'(sig_data),  0);
        chk("rst_valid",   32'(sig_valid), 0);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_done",    32'(done),      0);
        chk("rst_overrun", 32'(overrun),   0);
        rst = 1'b0;
        step();

        // Single pass, always ready; start pulsed mid-pass must be ignored
        for (int i = 0; i < SL; i++) sb_q.push_back(mem[i]);
        loop_en = 1'b0; fir_ready = 1'b1;
        start = 1'b1; cyc = 0;
        for (int i = 0; i < 14; i++) begin
            while (cyc < tv[i].c) begin
                step();
                start = 1'b0;
            end
            chk($sformatf("t1_rden_c%0d",  tv[i].c), 32'(bram_rden), 32'(tv[i].rden));
            chk($sformatf("t1_addr_c%0d",  tv[i].c), 32'(bram_addr), 32'(tv[i].addr));
            chk($sformatf("t1_valid_c%0d", tv[i].c), 32'(sig_valid), 32'(tv[i].valid));
            chk($sformatf("t1_data_c%0d",  tv[i].c), 32'(sig_data),  32'(tv[i].data));
            chk($sformatf("t1_busy_c%0d",  tv[i].c), 32'(busy),      32'(tv[i].busy));
            chk($sformatf("t1_done_c%0d",  tv[i].c), 32'(done),      32'(tv[i].done));
            start = tv[i].start;
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("t1_stop_done", 32'(done), 0);
        chk("t1_stop_busy", 32'(busy), 0);
        chk("t1_sb_empty", 32'(sb_q.size()), 0);

        // Looping: fifth sample wraps to address 0, never done
        for (int i = 0; i < SL; i++) sb_q.push_back(mem[i]);
        sb_q.push_back(mem[0]);
        loop_en = 1'b1; fir_ready = 1'b1;
        x0 = xfers; bad = 0;
        start = 1'b1; cyc = 0;
        while (cyc < 24) begin
            step();
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (cyc == 21) begin
                chk("t2_wrap_rden", 32'(bram_rden), 1);
                chk("t2_wrap_addr", 32'(bram_addr), 0);
            end
        end
        chk("t2_busy_no_done", 32'(bad), 0);
        chk("t2_xfers", 32'(xfers - x0), 5);
        stop = 1'b1; step(); stop = 1'b0; loop_en = 1'b0;
        chk("t2_stop_busy",  32'(busy),      0);
        chk("t2_stop_valid", 32'(sig_valid), 0);
        chk("t2_sb_empty", 32'(sb_q.size()), 0);

        // Back-pressure: held sample, dropped tick, overrun flag
        for (int i = 0; i < SL; i++) sb_q.push_back(mem[i]);
        fir_ready = 1'b1;
        start = 1'b1; cyc = 0;
        while (cyc < 7) begin
            step();
            start = 1'b0;
        end
        fir_ready = 1'b0;
        while (cyc < 12) begin
            step();
            chk($sformatf("t3_valid_c%0d", cyc), 32'(sig_valid), 1);
            chk($sformatf("t3_data_c%0d",  cyc), 32'(sig_data),  32'h0010);
        end
        step();
        chk("t3_overrun", 32'(overrun), 32'(OVR_EN));
        fir_ready = 1'b1;
        while (cyc < 17) begin
            step();
            chk($sformatf("t3_rden_c%0d", cyc), 32'(bram_rden), (cyc == 17) ? 1 : 0);
        end
        chk("t3_addr_after", 32'(bram_addr), 1);
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        chk("t3_done", 32'(done), 1);
        chk("t3_overrun_sticky", 32'(overrun), 32'(OVR_EN));
        chk("t3_sb_empty", 32'(sb_q.size()), 0);
        start = 1'b1; step(); start = 1'b0;
        chk("t3_restart_ovr_clr", 32'(overrun), 0);
        chk("t3_restart_busy",    32'(busy),    1);
        stop = 1'b1; step(); stop = 1'b0;

        // Stop while presenting, then restart from address 0
        fir_ready = 1'b0;
        start = 1'b1; cyc = 0;
        while (cyc < 7) begin
            step();
            start = 1'b0;
        end
        chk("t4_present_valid", 32'(sig_valid), 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t4_stop_valid", 32'(sig_valid), 0);
        chk("t4_stop_busy",  32'(busy),      0);
        chk("t4_stop_rden",  32'(bram_rden), 0);
        sb_q.push_back(mem[0]);
        fir_ready = 1'b1;
        start = 1'b1; cyc = 0;
        while (cyc < 5) begin
            step();
            start = 1'b0;
        end
        chk("t4_re_rden", 32'(bram_rden), 1);
        chk("t4_re_addr", 32'(bram_addr), 0);
        while (cyc < 8) step();
        stop = 1'b1; step(); stop = 1'b0;
        chk("t4_sb_empty", 32'(sb_q.size()), 0);

        // Reset in CAPTURE, then start+stop together in IDLE
        fir_ready = 1'b1;
        start = 1'b1; cyc = 0;
        while (cyc < 6) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_rden",    32'(bram_rden), 0);
        chk("t5_addr",    32'(bram_addr), 0);
        chk("t5_data",    32'(sig_data),  0);
        chk("t5_valid",   32'(sig_valid), 0);
        chk("t5_busy",    32'(busy),      0);
        chk("t5_done",    32'(done),      0);
        chk("t5_overrun", 32'(overrun),   0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("t5_ss_busy", 32'(busy), 0);
        chk("t5_ss_done", 32'(done), 0);
        repeat (6) step();
        chk("t5_ss_rden", 32'(bram_rden), 0);
        chk("t5_ss_busy_late", 32'(busy), 0);
        chk("t5_sb_empty", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 16, sample data width.
REQ-002 SHALL have parameter ADDR_W, default 7, BRAM address width.
REQ-003 SHALL have parameter SIG_LEN, default 100, number of samples per pass (2..2^ADDR_W).
REQ-004 SHALL have parameter CLK_DIV, default 12000, clocks per sample period (min 4).
REQ-005 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port i_start  input  1  begin pass from address 0 (sampled in IDLE or DONE).
REQ-008 SHALL have port i_stop  input  1  abort to IDLE.
REQ-009 SHALL have port i_loop  input  1  wrap to address 0 after last sample instead of finishing.
REQ-010 SHALL have port o_bram_rden  output  1  BRAM read enable.
REQ-011 SHALL have port o_bram_addr  output  ADDR_W  BRAM read address.
REQ-012 SHALL have port i_bram_data  input  SIG_WIDTH  BRAM read data, valid one cycle after rden.
REQ-013 SHALL have port o_sig_data  output  SIG_WIDTH  sample to FIR.
REQ-014 SHALL have port o_sig_valid  output  1  sample valid to FIR.
REQ-015 SHALL have port i_fir_ready  input  1  FIR accepts sample.
REQ-016 SHALL have ports o_busy, o_done, o_overrun  output  1 each  running, pass complete, sample tick missed.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_TICK, READ, CAPTURE, PRESENT, DONE.
REQ-018 IDLE/DONE + i_start -> WAIT_TICK; index and tick counter cleared to 0; o_done cleared.
REQ-019 Tick counter SHALL run 0..CLK_DIV-1 and wrap in all states except IDLE/DONE; tick = counter==CLK_DIV-1.
REQ-020 i_start in cycle s SHALL give first tick in cycle s+CLK_DIV; thereafter ticks exactly every CLK_DIV cycles.
REQ-021 WAIT_TICK + tick (cycle t) -> READ: o_bram_rden=1, o_bram_addr=index in t+1 only; rden=0 in all other states.
REQ-022 CAPTURE (t+2): i_bram_data SHALL be registered into o_sig_data; PRESENT (t+3): o_sig_valid=1.
REQ-023 o_sig_valid and o_sig_data SHALL hold stable until o_sig_valid&&i_fir_ready; transfer deasserts valid next cycle.
REQ-024 On transfer with index<SIG_LEN-1: index+1, -> WAIT_TICK.
REQ-025 On transfer with index==SIG_LEN-1: i_loop=1 -> index 0, WAIT_TICK; i_loop=0 -> DONE, o_done=1.
REQ-026 o_done SHALL hold in DONE until i_start, i_stop or reset.
REQ-027 o_busy=1 in WAIT_TICK, READ, CAPTURE, PRESENT; 0 otherwise.
REQ-028 i_stop SHALL force IDLE from any state next cycle, clearing o_sig_valid, o_bram_rden, o_done; priority over i_start and transfer.
REQ-029 i_start while busy SHALL be ignored.
REQ-030 Tick in READ, CAPTURE or PRESENT SHALL be dropped (no queued read); pending sample keeps being presented.
REQ-031 o_bram_addr SHALL hold last value outside READ.

Reset
REQ-032 i_rst=1 SHALL force IDLE, index=0, counter=0, o_bram_rden=0, o_bram_addr=0, o_sig_data=0, o_sig_valid=0, o_busy=0, o_done=0, o_overrun=0.
REQ-033 Reset mid-pass SHALL discard the pending sample; no output transfer in the reset cycle.

Configuration
REQ-034 Macro SAMPLE_SEQ_OVERRUN_EN defined: dropped tick (REQ-030) SHALL set o_overrun sticky, cleared only by i_start in IDLE/DONE or reset.
REQ-035 Macro undefined: o_overrun SHALL be constant 0, no detection logic; all other behaviour identical.

Verification (CLK_DIV=4, SIG_LEN=4, BRAM = 0x0010,0x0020,0x0030,0x0040)
REQ-036 i_start at cycle 0, i_fir_ready=1, i_loop=0 -> rden at cycles 5,9,13,17 with addr 0..3; valid at 7,11,15,19 with data 0x0010..0x0040; o_done=1 from 20.
REQ-037 i_loop=1, ready=1 -> fifth presented sample is 0x0010 (addr 0), o_done stays 0, o_busy stays 1.
REQ-038 i_fir_ready=0 for 6 cycles after first valid -> data 0x0010 held stable, next tick dropped, o_overrun=1 (macro defined) or 0 (undefined), next sample after release is 0x0020.
REQ-039 i_stop asserted in PRESENT -> next cycle IDLE, o_sig_valid=0, o_busy=0; subsequent i_start restarts at addr 0.
REQ-040 i_rst pulsed in CAPTURE -> all outputs at REQ-032 values next cycle; i_start and i_stop same cycle in IDLE -> remains IDLE.
